// File: rtl/pong_phys.sv
// rtl/pong_phys.sv - per-frame ball physics: N_PAD paddle checks, wall check, then one move step
module pong_phys #(
   parameter int S_WIDTH  = 640,
   parameter int S_HEIGHT = 480,
   parameter int BALL_W   = 10,
   parameter int BALL_H   = 10,
   parameter int PAD_W    = 10,
   parameter int PAD_H    = 60,
   parameter int N_PAD    = 2,
   parameter int SPEED_X  = 4,
   parameter int SPEED_Y  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_tick,
   input  logic                  serve,
   input  logic                  serve_dir,
   input  logic [10*N_PAD-1:0]   pad_x,
   input  logic [9*N_PAD-1:0]    pad_y,
   output logic [9:0]            ball_x,
   output logic [8:0]            ball_y,
   output logic                  running,
   output logic                  busy,
   output logic                  done,
   output logic [N_PAD-1:0]      hit_pad,
   output logic [1:0]            score
);
   localparam int PW = (N_PAD > 1) ? $clog2(N_PAD) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(N_PAD - 1);
   localparam logic [9:0]  X_MID = 10'(S_WIDTH / 2);
   localparam logic [8:0]  Y_MID = 9'(S_HEIGHT / 2);
   localparam logic [9:0]  X_MIN = 10'(BALL_W / 2);
   localparam logic [9:0]  X_MAX = 10'(S_WIDTH - BALL_W / 2);
   localparam logic [8:0]  Y_MIN = 9'(BALL_H / 2);
   localparam logic [8:0]  Y_MAX = 9'(S_HEIGHT - BALL_H / 2);
   localparam logic [9:0]  X_LO  = 10'(BALL_W / 2 + SPEED_X);
   localparam logic [9:0]  X_HI  = 10'(S_WIDTH - BALL_W / 2 - SPEED_X);
   localparam logic [8:0]  Y_LO  = 9'(BALL_H / 2 + SPEED_Y);
   localparam logic [8:0]  Y_HI  = 9'(S_HEIGHT - BALL_H / 2 - SPEED_Y);
   localparam logic [9:0]  SPX   = 10'(SPEED_X);
   localparam logic [8:0]  SPY   = 9'(SPEED_Y);
   localparam logic [10:0] HIT_X = 11'(BALL_W + PAD_W);
   localparam logic [9:0]  HIT_Y = 10'(BALL_H + PAD_H);

   typedef enum logic [1:0] {S_IDLE, S_PAD, S_WALL, S_MOVE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    pidx_q, pidx_d;
   logic [9:0]       bx_q, bx_d;
   logic [8:0]       by_q, by_d;
   logic             dxn_q, dxn_d, dyn_q, dyn_d;
   logic             run_q, run_d;
   logic [N_PAD-1:0] hits_q, hits_d, hit_pad_q, hit_pad_d;
   logic [1:0]       spend_q, spend_d, score_q, score_d;
   logic             done_q, done_d;

   logic [9:0] px, adx;
   logic [8:0] py, ady;
   logic       pad_hit;

   // Overlap of the ball against the paddle selected by pidx_q, doubled to avoid halving odd sizes
   always_comb begin
      px = '0;
      py = '0;
      for (int i = 0; i < N_PAD; i++) begin
         if (pidx_q == PW'(i)) begin
            px = pad_x[10*i +: 10];
            py = pad_y[9*i +: 9];
         end
      end
      adx     = (bx_q >= px) ? (bx_q - px) : (px - bx_q);
      ady     = (by_q >= py) ? (by_q - py) : (py - by_q);
      pad_hit = ({adx, 1'b0} <= HIT_X) && ({ady, 1'b0} <= HIT_Y);
   end

   always_comb begin
      state_d   = state_q;
      pidx_d    = pidx_q;
      bx_d      = bx_q;
      by_d      = by_q;
      dxn_d     = dxn_q;
      dyn_d     = dyn_q;
      run_d     = run_q;
      hits_d    = hits_q;
      spend_d   = spend_q;
      hit_pad_d = '0;
      score_d   = '0;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!run_q && serve) begin
               run_d = 1'b1;
               dxn_d = serve_dir;
            end else if (run_q && frame_tick) begin
               state_d = S_PAD;
               pidx_d  = '0;
               hits_d  = '0;
            end
         end
         S_PAD: begin
            if (pad_hit) begin
               dxn_d = (px >= X_MID);
               for (int i = 0; i < N_PAD; i++) begin
                  if (pidx_q == PW'(i)) hits_d[i] = 1'b1;
               end
            end
            if (pidx_q == P_LAST) begin
               state_d = S_WALL;
               pidx_d  = '0;
            end else begin
               pidx_d = pidx_q + 1'b1;
            end
         end
         S_WALL: begin
            if (by_q <= Y_MIN)      dyn_d = 1'b0;
            else if (by_q >= Y_MAX) dyn_d = 1'b1;
            spend_d = '0;
            if (hits_q == '0) begin
               if (bx_q <= X_MIN)      spend_d = 2'b10;
               else if (bx_q >= X_MAX) spend_d = 2'b01;
            end
            state_d = S_MOVE;
         end
         S_MOVE: begin
            done_d    = 1'b1;
            hit_pad_d = hits_q;
            score_d   = spend_q;
            state_d   = S_IDLE;
            if (spend_q != 2'b00) begin
               bx_d  = X_MID;
               by_d  = Y_MID;
               run_d = 1'b0;
            end else begin
               // Compare against the clamp bound first so the subtract can never wrap
               if (dxn_q) bx_d = (bx_q <= X_LO) ? X_MIN : (bx_q - SPX);
               else       bx_d = (bx_q >= X_HI) ? X_MAX : (bx_q + SPX);
               if (dyn_q) by_d = (by_q <= Y_LO) ? Y_MIN : (by_q - SPY);
               else       by_d = (by_q >= Y_HI) ? Y_MAX : (by_q + SPY);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pidx_q    <= '0;
         bx_q      <= X_MID;
         by_q      <= Y_MID;
         dxn_q     <= 1'b0;
         dyn_q     <= 1'b0;
         run_q     <= 1'b0;
         hits_q    <= '0;
         spend_q   <= '0;
         hit_pad_q <= '0;
         score_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pidx_q    <= pidx_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         dxn_q     <= dxn_d;
         dyn_q     <= dyn_d;
         run_q     <= run_d;
         hits_q    <= hits_d;
         spend_q   <= spend_d;
         hit_pad_q <= hit_pad_d;
         score_q   <= score_d;
         done_q    <= done_d;
      end
   end

   assign ball_x  = bx_q;
   assign ball_y  = by_q;
   assign running = run_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign hit_pad = hit_pad_q;
   assign score   = score_q;
endmodule

// File: tb/tb_pong_phys.sv
// tb/tb_pong_phys.sv - randomized frames against a frame-level reference model, plus pinned literal cases
module tb_pong_phys;
   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            frame_tick = 1'b0;
   logic            serve = 1'b0;
   logic            serve_dir = 1'b0;
   logic [10*N-1:0] pad_x = '0;
   logic [9*N-1:0]  pad_y = '0;
   logic [9:0]      ball_x;
   logic [8:0]      ball_y;
   logic            running, busy, done;
   logic [N-1:0]    hit_pad;
   logic [1:0]      score;

   int n_checks = 0;
   int n_err = 0;

   // model state: positions as plain ints, direction flags 1 = negative
   int m_x, m_y, m_dxn, m_dyn, m_run, m_cnt, m_done, m_hit, m_score;
   int r_x, r_y, r_dxn, r_dyn, r_run, r_hit, r_score;

   pong_phys #(.N_PAD(N)) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve),
      .serve_dir(serve_dir), .pad_x(pad_x), .pad_y(pad_y),
      .ball_x(ball_x), .ball_y(ball_y), .running(running), .busy(busy),
      .done(done), .hit_pad(hit_pad), .score(score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_reset();
      m_x = 320; m_y = 240; m_dxn = 0; m_dyn = 0; m_run = 0;
      m_cnt = 0; m_done = 0; m_hit = 0; m_score = 0;
   endtask

   // Whole-frame outcome, evaluated once at the tick with the paddles the source holds steady
   task automatic frame_result();
      int px, py;
      r_hit = 0; r_dxn = m_dxn; r_dyn = m_dyn; r_score = 0;
      for (int i = 0; i < N; i++) begin
         px = int'(pad_x[10*i +: 10]);
         py = int'(pad_y[9*i +: 9]);
         if (2 * iabs(m_x - px) <= 20 && 2 * iabs(m_y - py) <= 70) begin
            r_hit |= (1 << i);
            r_dxn = (px >= 320) ? 1 : 0;
         end
      end
      if (m_y <= 5) r_dyn = 0;
      else if (m_y >= 475) r_dyn = 1;
      if (r_hit == 0) begin
         if (m_x <= 5) r_score = 2;
         else if (m_x >= 635) r_score = 1;
      end
      if (r_score != 0) begin
         r_x = 320; r_y = 240; r_run = 0;
      end else begin
         r_x = clampi(m_x + (r_dxn ? -4 : 4), 5, 635);
         r_y = clampi(m_y + (r_dyn ? -3 : 3), 5, 475);
         r_run = 1;
      end
   endtask

   task automatic model_step(input int t, input int s, input int d);
      m_done = 0; m_hit = 0; m_score = 0;
      if (m_cnt == 0) begin
         if (m_run == 0 && s != 0) begin
            m_run = 1; m_dxn = d;
         end else if (m_run != 0 && t != 0) begin
            frame_result();
            m_cnt = N + 2;
         end
      end else begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_x = r_x; m_y = r_y; m_dxn = r_dxn; m_dyn = r_dyn; m_run = r_run;
            m_done = 1; m_hit = r_hit; m_score = r_score;
         end
      end
   endtask

   task automatic check_outputs();
      chk("ball_x", int'(ball_x), m_x);
      chk("ball_y", int'(ball_y), m_y);
      chk("running", int'(running), m_run);
      chk("busy", int'(busy), (m_cnt != 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("hit_pad", int'(hit_pad), m_hit);
      chk("score", int'(score), m_score);
   endtask

   task automatic cycle(input int t, input int s, input int d);
      frame_tick = (t != 0);
      serve = (s != 0);
      serve_dir = (d != 0);
      @(posedge clk);
      model_step(t, s, d);
      #1;
      check_outputs();
   endtask

   task automatic set_pads(input int mode);
      int x0, y0, x1, y1;
      case (mode)
         0: begin
            x0 = $urandom_range(0, 639); y0 = $urandom_range(0, 479);
            x1 = $urandom_range(0, 639); y1 = $urandom_range(0, 479);
         end
         1: begin
            x0 = clampi(m_x + $urandom_range(0, 24) - 12, 0, 1023);
            y0 = clampi(m_y + $urandom_range(0, 70) - 35, 0, 511);
            x1 = $urandom_range(0, 639); y1 = $urandom_range(0, 479);
         end
         default: begin
            x0 = 10 + $urandom_range(0, 20);
            y0 = clampi(m_y + $urandom_range(0, 90) - 45, 0, 511);
            x1 = 610 + $urandom_range(0, 20);
            y1 = clampi(m_y + $urandom_range(0, 90) - 45, 0, 511);
         end
      endcase
      pad_x = {10'(x1), 10'(x0)};
      pad_y = {9'(y1), 9'(y0)};
   endtask

   initial begin
      int lat, nb, did_rst;
      model_reset();
      pad_x = {10'd620, 10'd20};
      pad_y = {9'd0, 9'd0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ball_x", int'(ball_x), 320);
      chk("reset_ball_y", int'(ball_y), 240);
      chk("reset_running", int'(running), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      check_outputs();
      rst_n = 1'b1;

      cycle(1, 0, 0);
      chk("tick_not_running_busy", int'(busy), 0);
      cycle(0, 1, 0);
      chk("serve_running", int'(running), 1);

      for (int k = 1; k <= 3; k++) begin
         lat = 0; nb = 0;
         do begin
            cycle((lat == 0 || (k == 3 && lat == 2)) ? 1 : 0, 0, 0);
            lat++;
            if (busy) nb++;
         end while (!done && lat < 20);
         chk("done_latency", lat, 5);
         chk("busy_cycles", nb, 4);
         chk("lit_ball_x", int'(ball_x), 320 + 4 * k);
         chk("lit_ball_y", int'(ball_y), 240 + 3 * k);
      end
      cycle(0, 0, 0);
      chk("no_restart_busy", int'(busy), 0);

      did_rst = 0;
      for (int f = 0; f < 500; f++) begin
         repeat ($urandom_range(0, 2)) cycle(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
         if (m_run == 0) begin
            if ($urandom_range(0, 3) == 0) cycle(1, 0, 0);
            cycle($urandom_range(0, 1), 1, $urandom_range(0, 1));
         end
         set_pads($urandom_range(0, 5));
         cycle(1, $urandom_range(0, 1), $urandom_range(0, 1));
         while (m_cnt != 0) begin
            if (did_rst == 0 && f >= 150 && m_cnt == 2) begin
               frame_tick = 1'b0;
               serve = 1'b0;
               rst_n = 1'b0;
               #1;
               model_reset();
               chk("midreset_ball_x", int'(ball_x), 320);
               chk("midreset_busy", int'(busy), 0);
               check_outputs();
               @(posedge clk);
               #1;
               check_outputs();
               rst_n = 1'b1;
               did_rst = 1;
            end else begin
               cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            end
         end
      end
      chk("midreset_done", did_rst, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
